// File: rtl/down_counter8_tff_pkg.sv
// Shared definitions for the down-counter family: default width and the wrap value.
package down_counter8_tff_pkg;

  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

endpackage : down_counter8_tff_pkg

// File: rtl/down_counter8_tff_tff_sync.sv
// Behavioural T flip-flop with synchronous active-high clear.
module tff_sync (
  input  logic clk,
  input  logic clear,
  input  logic t,
  output logic q
);

  logic q_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule : tff_sync

// File: rtl/down_counter8_tff.sv
// Loadable down counter built from T flip-flops; load is applied through the
// T inputs (T = q ^ d), and borrow flags the cycle after a 0 -> all-ones wrap.
module down_counter8_tff
  import down_counter8_tff_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] t;
  logic [WIDTH:0]   low_zero;
  logic             borrow_q;
  logic             borrow_d;

  // low_zero[i] is high when bits 0..i-1 are all zero, i.e. bit i must toggle on a decrement.
  assign low_zero[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign low_zero[i+1] = low_zero[i] & ~cnt_q[i];
    assign t[i] = (load & (cnt_q[i] ^ d[i])) | (~load & enable & low_zero[i]);

    tff_sync u_tff (
      .clk   (clk),
      .clear (clear),
      .t     (t[i]),
      .q     (cnt_q[i])
    );
  end

  assign zero     = low_zero[WIDTH];
  assign borrow_d = enable & ~load & low_zero[WIDTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      borrow_q <= 1'b0;
    end else begin
      borrow_q <= borrow_d;
    end
  end

  assign q      = cnt_q;
  assign borrow = borrow_q;

endmodule : down_counter8_tff

// File: doc/down_counter8_tff.md
DOWN_COUNTER8_TFF -- requirements
Module: down_counter8_tff

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits; all behaviour below is stated for WIDTH=8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port enable, input, 1 bit: count-down enable.
REQ-005 The block SHALL have port load, input, 1 bit: parallel-load strobe.
REQ-006 The block SHALL have port d, input, WIDTH bits: the parallel-load value.
REQ-007 The block SHALL have port q, output, WIDTH bits: the current count, driven directly from the flip-flops.
REQ-008 The block SHALL have port zero, output, 1 bit: combinational flag, high when q == 0.
REQ-009 The block SHALL have port borrow, output, 1 bit: registered single-cycle pulse marking a wrap from 0 to all-ones.

Function
REQ-010 Priority at each rising clk edge SHALL be clear > load > enable > hold.
REQ-011 When load=1 and clear=0, q SHALL take d on the next edge, whatever enable is.
REQ-012 When enable=1, load=0 and clear=0, the next q SHALL be (q - 1) mod 2^WIDTH.
REQ-013 When enable=0, load=0 and clear=0, q SHALL hold its value.
REQ-014 Decrement logic SHALL be T-style: bit i toggles when enable=1 and bits 0..i-1 are all 0; bit 0 toggles on every enabled edge.
REQ-015 Load SHALL be realised through the T inputs: T_i = q_i XOR d_i, so no D-path bypasses the T flip-flops.
REQ-016 Wrap-around: a decrement from 0x00 SHALL produce 0x FF and assert borrow for exactly the next cycle.
REQ-017 borrow SHALL be 0 on every cycle except the one immediately following an enabled decrement from 0.
REQ-018 A load on the same edge where q=0 and enable=1 SHALL take priority: q=d and borrow=0.
REQ-019 zero SHALL update in the same cycle that q changes, with no added latency.
REQ-020 The latency from control input to q SHALL be one clock edge; there is no pipelining.
REQ-021 Repeated enables from a loaded value N SHALL reach 0 after exactly N enabled edges; zero is high in that cycle.

Reset
REQ-022 On a rising edge with clear=1, the next values SHALL be q=0x00 and borrow=0; consequently zero=1.
REQ-023 clear SHALL override load and enable on the same edge, including when applied mid-count.
REQ-024 The block SHALL have no asynchronous reset path; clear changes between edges SHALL have no effect until the next edge.

Structure
REQ-025 The WIDTH default and the ALL_ONES constant SHALL be placed in the shared counter definitions package/header used by the counter family.
REQ-026 The block SHALL contain one sub-module, tff_sync (clk, clear, t, q), written in behavioural style, with synchronous active-high clear.
REQ-027 The block SHALL instantiate WIDTH copies of tff_sync through a generate loop.
REQ-028 T-input generation, zero and the borrow-next logic SHALL be written in dataflow or gate-level style only.
REQ-029 The borrow register SHALL be a single behavioural flop in the top module, or a tff_sync driven as toggle-to-set; either choice must be synthesis-clean.

Verification
REQ-030 Reset test: drive clear=1 for 1 edge while load=1 and d=0x5A; then q=0x00, zero=1, borrow=0.
REQ-031 Load and count test: load d=0x03, then 3 enabled edges; q goes 03, 02, 01, 00 and zero=1 at 00.
REQ-032 Wrap test: with q=0x00, 1 enabled edge; q=0xFF and borrow=1 for exactly one cycle, then 0 with enable held.
REQ-033 Priority test: at q=0x00 with enable=1, assert load with d=0x80; q=0x80, borrow stays 0. Then clear=1 with load=1; q=0x00.
REQ-034 Hold and full-cycle test: with enable=0 for 10 edges, q stays constant. From 0xFF, 255 enabled edges reach 0x00, with the bench model matching q at every edge.
